// File: rtl/fit_window_scheduler.sv
// fit_window_scheduler: sweeps fixed-size windows over a stored series through
// one fit engine and keeps the window with the lowest deviation.
module fit_window_scheduler #(
  parameter int DW = 32,
  parameter int WATCHDOG = 1024
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          cfg_start,
  input  logic [DW-1:0] cfg_base,
  input  logic [DW-1:0] cfg_count,
  input  logic [DW-1:0] cfg_win,
  input  logic [DW-1:0] cfg_stride,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] win_count,
  output logic [DW-1:0] best_si,
  output logic [DW-1:0] best_dev,
  output logic [DW-1:0] best_mean,
  output logic [DW-1:0] fit_si,
  output logic [DW-1:0] fit_ei,
  output logic          fit_start,
  input  logic          fit_done,
  input  logic [DW-1:0] fit_deviation,
  input  logic [DW-1:0] fit_mean
);

  localparam int WW = $clog2(WATCHDOG + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(WATCHDOG - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, LAUNCH, WAIT_LOW, WAIT_HIGH, UPDATE, FINISH
  } state_t;

  state_t        state;
  logic [DW-1:0] base_q;
  logic [DW-1:0] count_q;
  logic [DW-1:0] win_q;
  logic [DW-1:0] stride_q;
  logic [WW-1:0] wd;

  logic [DW:0] lim;
  logic [DW:0] ei_next;
  logic [DW:0] si_next;
  logic        cfg_bad;

  // One extra bit so end-of-series and index wrap are visible as a carry.
  assign lim     = {1'b0, base_q} + {1'b0, count_q};
  assign ei_next = {1'b0, fit_si} + {1'b0, win_q};
  assign si_next = {1'b0, fit_si} + {1'b0, stride_q};
  assign cfg_bad = (win_q < DW'(2)) || (stride_q == '0) ||
                   (win_q > count_q) || lim[DW];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      fit_start <= 1'b0;
      win_count <= '0;
      fit_si    <= '0;
      fit_ei    <= '0;
      best_si   <= '0;
      best_mean <= '0;
      best_dev  <= '1;
      base_q    <= '0;
      count_q   <= '0;
      win_q     <= '0;
      stride_q  <= '0;
      wd        <= '0;
    end else begin
      fit_start <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            base_q    <= cfg_base;
            count_q   <= cfg_count;
            win_q     <= cfg_win;
            stride_q  <= cfg_stride;
            busy      <= 1'b1;
            err       <= 1'b0;
            win_count <= '0;
            best_si   <= '0;
            best_mean <= '0;
            best_dev  <= '1;
            fit_si    <= cfg_base;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (cfg_bad) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else if (ei_next > lim) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            fit_ei <= ei_next[DW-1:0];
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          // Engine may still be finishing a run cut short by reset.
          if (fit_done) begin
            fit_start <= 1'b1;
            wd        <= '0;
            state     <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!fit_done) begin
            state <= WAIT_HIGH;
          end else if (wd == WD_MAX) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (fit_done) state <= UPDATE;
        end
        UPDATE: begin
          win_count <= win_count + 1'b1;
          if (fit_deviation < best_dev) begin
            best_si   <= fit_si;
            best_dev  <= fit_deviation;
            best_mean <= fit_mean;
          end
          if (si_next[DW]) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            fit_si <= si_next[DW-1:0];
            state  <= CHECK;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fit_window_scheduler.sv
// tb_fit_window_scheduler: random and directed runs against a behavioural
// engine model and a window-list reference model.
module tb_fit_window_scheduler;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_count = '0;
  logic [31:0] cfg_win = '0;
  logic [31:0] cfg_stride = '0;
  logic        busy, done, err, fit_start;
  logic [31:0] win_count, best_si, best_dev, best_mean, fit_si, fit_ei;
  logic        fit_done = 1'b1;
  logic [31:0] fit_deviation = '0;
  logic [31:0] fit_mean = '0;

  fit_window_scheduler #(.DW(32), .WATCHDOG(16)) dut (
    .Clk(Clk), .Rst(Rst), .cfg_start(cfg_start),
    .cfg_base(cfg_base), .cfg_count(cfg_count),
    .cfg_win(cfg_win), .cfg_stride(cfg_stride),
    .busy(busy), .done(done), .err(err), .win_count(win_count),
    .best_si(best_si), .best_dev(best_dev), .best_mean(best_mean),
    .fit_si(fit_si), .fit_ei(fit_ei), .fit_start(fit_start),
    .fit_done(fit_done), .fit_deviation(fit_deviation),
    .fit_mean(fit_mean)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // mode 0: dev=100-si, 1: constant 5, 2: scrambled, 3: engine hangs
  function automatic logic [31:0] dev_of(input int m, input logic [31:0] si);
    if (m == 0) return 32'd100 - si;
    if (m == 1) return 32'd5;
    return (si * 32'd37 + 32'd7) % 32'd50;
  endfunction

  function automatic logic [31:0] mean_of(input logic [31:0] si);
    return si * 32'd3 + 32'd1;
  endfunction

  int          eng_mode = 0;
  bit          eng_long = 1'b0;
  int          eng_cnt = 0;
  logic [31:0] eng_si = '0;
  logic [31:0] l_si[$];
  logic [31:0] l_ei[$];
  longint      cyc = 0;
  longint      launch_cyc = 0;
  logic        prev_fs = 1'b0;
  int          dbl_viol = 0;
  int          stale_viol = 0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    prev_fs <= fit_start;
    if (fit_start && prev_fs) dbl_viol <= dbl_viol + 1;
    if (fit_start) begin
      if (!fit_done) stale_viol <= stale_viol + 1;
      l_si.push_back(fit_si);
      l_ei.push_back(fit_ei);
      launch_cyc <= cyc;
      if (eng_mode != 3) begin
        fit_done <= 1'b0;
        eng_cnt <= eng_long ? 40 : int'($urandom_range(1, 6));
        eng_si <= fit_si;
      end
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        fit_done <= 1'b1;
        fit_deviation <= dev_of(eng_mode, eng_si);
        fit_mean <= mean_of(eng_si);
      end
    end
  end

  task automatic run(input logic [31:0] b, input logic [31:0] c,
                     input logic [31:0] w, input logic [31:0] s,
                     input int m, input bit rep);
    logic [32:0] lim;
    bit          xerr;
    logic [31:0] xsi[$];
    logic [31:0] xbd, xbs, xbm, d;
    longint      p;
    int          nwin, n;
    lim = {1'b0, b} + {1'b0, c};
    xerr = (w < 2) || (s == 0) || (w > c) || lim[32];
    if (!xerr) begin
      p = longint'(b);
      while (p + longint'(w) <= longint'(lim)) begin
        xsi.push_back(p[31:0]);
        p = p + longint'(s);
        if (p > 64'hffff_ffff) break;
      end
    end
    nwin = xsi.size();
    if (m == 3) begin
      xerr = 1'b1;
      nwin = 0;
      while (xsi.size() > 1) void'(xsi.pop_back());
    end
    xbd = '1; xbs = '0; xbm = '0;
    for (int i = 0; i < nwin; i++) begin
      d = dev_of(m, xsi[i]);
      if (d < xbd) begin
        xbd = d; xbs = xsi[i]; xbm = mean_of(xsi[i]);
      end
    end
    eng_mode = m;
    l_si.delete();
    l_ei.delete();
    cfg_base = b; cfg_count = c; cfg_win = w; cfg_stride = s;
    cfg_start = 1'b1;
    @(negedge Clk);
    cfg_start = 1'b0;
    chk("busy_start", busy, 1'b1);
    if (rep) begin
      cfg_base = 32'd500; cfg_count = 32'd3;
      cfg_win = 32'd2; cfg_stride = 32'd1;
    end
    n = 0;
    while (!done && n < 3000) begin
      cfg_start = rep && (n == 3 || n == 8);
      @(negedge Clk);
      n++;
    end
    cfg_start = 1'b0;
    if (!done) chk("done_timeout", n, 0);
    chk("err", err, xerr);
    chk("busy_end", busy, 1'b0);
    chk("win_count", win_count, nwin);
    chk("best_dev", best_dev, xbd);
    if (nwin > 0) begin
      chk("best_si", best_si, xbs);
      chk("best_mean", best_mean, xbm);
    end
    chk("n_launch", l_si.size(), xsi.size());
    for (int i = 0; i < xsi.size() && i < l_si.size(); i++) begin
      chk("launch_si", l_si[i], xsi[i]);
      chk("launch_ei", l_ei[i], xsi[i] + w);
    end
    if (xerr && m != 3) chk("err_latency", n, 1);
    if (m == 3) chk("wd_time", (cyc - launch_cyc) inside {[15:18]}, 1'b1);
    @(negedge Clk);
    chk("done_pulse", done, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_fs"}, fit_start, 1'b0);
    chk({tag, "_wc"}, win_count, 0);
    chk({tag, "_fsi"}, fit_si, 0);
    chk({tag, "_fei"}, fit_ei, 0);
    chk({tag, "_bsi"}, best_si, 0);
    chk({tag, "_bmean"}, best_mean, 0);
    chk({tag, "_bdev"}, best_dev, 32'hffff_ffff);
  endtask

  initial begin
    int n;
    logic [31:0] b, c, w, s;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    chk_reset_state("rst");

    run(0, 10, 4, 2, 0, 0);
    run(0, 10, 4, 2, 1, 0);
    run(0, 10, 1, 2, 0, 0);
    run(0, 10, 4, 0, 0, 0);
    run(0, 10, 11, 2, 0, 0);
    run(32'hffff_fff0, 32'h20, 4, 2, 0, 0);
    run(32'hffff_fff0, 32'h0e, 2, 32'h14, 2, 0);
    run(0, 10, 4, 2, 3, 0);
    run(0, 10, 4, 2, 0, 1);

    eng_mode = 0;
    eng_long = 1'b1;
    cfg_base = 0; cfg_count = 10; cfg_win = 4; cfg_stride = 2;
    cfg_start = 1'b1;
    @(negedge Clk);
    cfg_start = 1'b0;
    n = 0;
    while (fit_done && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (fit_done) chk("reset_setup_timeout", n, 0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    eng_long = 1'b0;
    chk_reset_state("midrst");
    run(0, 10, 4, 2, 0, 0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0)
        b = 32'hffff_ffff - $urandom_range(0, 40);
      else
        b = $urandom_range(0, 1000);
      c = $urandom_range(0, 40);
      w = $urandom_range(0, 12);
      s = $urandom_range(0, 14);
      run(b, c, w, s, 2, 0);
    end

    chk("dbl_start", dbl_viol, 0);
    chk("stale_start", stale_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
